// File: rtl/timer_duty_sequencer.sv
// timer_duty_sequencer: bus master that walks a counter_timer compare register (cmpr0/cmpr1)
// through a CPU-loaded duty table, one entry per REPEAT+1 top events.
// Optional feature macro: SEQ_MIRROR_EN enables the ping-pong walk selected by CONTROL[4].
module timer_duty_sequencer #(
  parameter logic [7:0]  SEQ_ADDRESS   = 8'h00,
  parameter logic [7:0]  TIMER_ADDRESS = 8'h00,
  parameter int unsigned DEPTH         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] din,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic [7:0] t_address,
  output logic [7:0] t_din,
  output logic       t_req,
  input  logic       t_gnt,
  output logic       t_w_en,
  input  logic       top_flag,
  output logic       top_flag_clr,
  output logic       done_irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWaitTop, StClear} state_e;

  state_e          state_q, state_d;
  logic            ctrl_en_q, ctrl_loop_q, ctrl_tgt_q, ctrl_irq_q;
  logic [AW-1:0]   length_q, ptr_q, idx_q, idx_d;
  logic [7:0]      repeat_q, hold_q, hold_d;
  logic            done_q, set_done, clr_en;
  logic [7:0]      tdin_q, taddr_q, rdata;
  logic [7:0]      table_mem [DEPTH];
  logic            mir_bit;
  logic            adv_end;
  logic [AW-1:0]   adv_next, restart_idx;
`ifdef SEQ_MIRROR_EN
  logic            ctrl_mir_q, dir_q, dir_d;
  assign mir_bit = ctrl_mir_q;
`else
  assign mir_bit = 1'b0;
`endif

  logic wr_ctrl, wr_len, wr_ptr, wr_data, wr_stat, wr_rep, tgt_now;
  assign wr_ctrl = w_en && (address == SEQ_ADDRESS);
  assign wr_len  = w_en && (address == SEQ_ADDRESS + 8'd1);
  assign wr_ptr  = w_en && (address == SEQ_ADDRESS + 8'd2);
  assign wr_data = w_en && (address == SEQ_ADDRESS + 8'd3);
  assign wr_stat = w_en && (address == SEQ_ADDRESS + 8'd4);
  assign wr_rep  = w_en && (address == SEQ_ADDRESS + 8'd5);
  // A starting CONTROL write selects the target in the same cycle it enables.
  assign tgt_now = wr_ctrl ? din[2] : ctrl_tgt_q;

  // Next-state logic: walk the table, count top events, handle CPU abort.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    set_done    = 1'b0;
    clr_en      = 1'b0;
    adv_end     = (idx_q == length_q);
    adv_next    = idx_q + 1'b1;
    restart_idx = '0;
`ifdef SEQ_MIRROR_EN
    dir_d       = dir_q;
    if (ctrl_mir_q && (length_q != '0)) begin
      if (!dir_q) begin
        adv_end = 1'b0;
        if (idx_q == length_q) begin
          dir_d    = 1'b1;
          adv_next = idx_q - 1'b1;
        end
      end else begin
        adv_end     = (idx_q == '0);
        adv_next    = idx_q - 1'b1;
        restart_idx = AW'(1);
      end
    end
`endif
    case (state_q)
      StIdle: begin
        if (wr_ctrl && din[0] && !ctrl_en_q) begin
          state_d = StReq;
          idx_d   = '0;
          hold_d  = '0;
`ifdef SEQ_MIRROR_EN
          dir_d   = 1'b0;
`endif
        end
      end
      StReq: if (t_gnt) state_d = StWaitTop;
      StWaitTop: if (top_flag) state_d = StClear;
      StClear: begin
        if (hold_q != repeat_q) begin
          hold_d  = hold_q + 8'd1;
          state_d = StWaitTop;
        end else begin
          hold_d = '0;
          if (!adv_end) begin
            idx_d   = adv_next;
            state_d = StReq;
          end else if (ctrl_loop_q) begin
            idx_d   = restart_idx;
`ifdef SEQ_MIRROR_EN
            dir_d   = 1'b0;
`endif
            state_d = StReq;
          end else begin
            set_done = 1'b1;
            clr_en   = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // CPU clearing enable aborts the run without signalling done.
    if ((state_q != StIdle) && wr_ctrl && !din[0]) begin
      state_d  = StIdle;
      set_done = 1'b0;
      clr_en   = 1'b0;
    end
  end

  // State, CPU registers and the latched timer write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hold_q      <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_loop_q <= 1'b0;
      ctrl_tgt_q  <= 1'b0;
      ctrl_irq_q  <= 1'b0;
      length_q    <= '0;
      ptr_q       <= '0;
      repeat_q    <= '0;
      done_q      <= 1'b0;
      tdin_q      <= '0;
      taddr_q     <= '0;
      dout        <= '0;
`ifdef SEQ_MIRROR_EN
      ctrl_mir_q  <= 1'b0;
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
`ifdef SEQ_MIRROR_EN
      dir_q   <= dir_d;
      if (wr_ctrl) ctrl_mir_q <= din[4];
`endif
      if (wr_ctrl) begin
        ctrl_en_q   <= din[0];
        ctrl_loop_q <= din[1];
        ctrl_tgt_q  <= din[2];
        ctrl_irq_q  <= din[3];
      end
      if (clr_en) ctrl_en_q <= 1'b0;
      if (wr_len) length_q <= din[AW-1:0];
      if (wr_ptr) ptr_q <= din[AW-1:0];
      else if (wr_data) ptr_q <= ptr_q + 1'b1;
      if (wr_rep) repeat_q <= din;
      if (wr_stat && !din[1]) done_q <= 1'b0;
      if (set_done) done_q <= 1'b1;
      // Address and data are captured on entry to REQ so they stay stable while stalled.
      if ((state_d == StReq) && (state_q != StReq)) begin
        tdin_q  <= table_mem[idx_d];
        taddr_q <= TIMER_ADDRESS + 8'd3 + {7'd0, tgt_now};
      end
      if (r_en) dout <= rdata;
    end
  end

  // Duty table storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_data) table_mem[ptr_q] <= din;
  end

  // CPU read mux; unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    if (address == SEQ_ADDRESS) begin
      rdata = {3'b000, mir_bit, ctrl_irq_q, ctrl_tgt_q, ctrl_loop_q, ctrl_en_q};
    end else if (address == SEQ_ADDRESS + 8'd1) begin
      rdata = 8'(length_q);
    end else if (address == SEQ_ADDRESS + 8'd2) begin
      rdata = 8'(ptr_q);
    end else if (address == SEQ_ADDRESS + 8'd3) begin
      rdata = table_mem[ptr_q];
    end else if (address == SEQ_ADDRESS + 8'd4) begin
      rdata = {4'(idx_q), 2'b00, done_q, (state_q != StIdle)};
    end else if (address == SEQ_ADDRESS + 8'd5) begin
      rdata = repeat_q;
    end
  end

  assign t_req        = (state_q == StReq);
  assign t_address    = t_req ? taddr_q : 8'h00;
  assign t_din        = t_req ? tdin_q : 8'h00;
  assign t_w_en       = t_req & t_gnt;
  assign top_flag_clr = (state_q == StClear);
  assign done_irq     = done_q & ctrl_irq_q;

endmodule
